io_access_decoder: RTL and testbench

- Processor-side front end of the peripheral register bank. It sits directly upstream of the per-register read/write register slices.
- Accepts single processor I/O accesses and decodes the word address into a one-hot register select. It issues a single-cycle write strobe, muxes the selected register's read data, and returns a registered Ready/Error response.
- Unmapped accesses are flagged and never touch any register.

---
 rtl/io_access_decoder_if.sv | 35 +++
 rtl/io_access_decoder.sv | 168 ++++++++++++++++
 tb/tb_io_access_decoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/io_access_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : io_access_decoder_if
// Description : Processor I/O access bus and register-slice bus bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_access_decoder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8
);
    logic                           Cpu_Req;
    logic                           Cpu_WrEn;
    logic [ADDR_WIDTH-1:0]          Cpu_Addr;
    logic [DATA_WIDTH-1:0]          Cpu_WrData;
    logic [DATA_WIDTH-1:0]          Cpu_RdData;
    logic                           Cpu_Ready;
    logic                           Cpu_Error;
    logic [NUM_REGS-1:0]            Reg_Select;
    logic                           Reg_WrEn;
    logic [DATA_WIDTH-1:0]          Reg_WrData;
    logic [NUM_REGS*DATA_WIDTH-1:0] Reg_RdData;

    // Environment side: processor plus the register slices.
    modport master (
        output Cpu_Req, Cpu_WrEn, Cpu_Addr, Cpu_WrData, Reg_RdData,
        input  Cpu_RdData, Cpu_Ready, Cpu_Error, Reg_Select, Reg_WrEn, Reg_WrData
    );

    modport slave (
        input  Cpu_Req, Cpu_WrEn, Cpu_Addr, Cpu_WrData, Reg_RdData,
        output Cpu_RdData, Cpu_Ready, Cpu_Error, Reg_Select, Reg_WrEn, Reg_WrData
    );
endinterface
`default_nettype wire

// File: rtl/io_access_decoder.sv
`default_nettype none
// ============================================================================
// Module      : io_access_decoder
// Description : Decodes single processor I/O accesses onto a bank of register
//               slices with a registered Ready/Error response.
//               Optional macro IO_ERR_STATUS_EN adds an unmapped-access counter
//               at word address BASE_ADDR+NUM_REGS.
// Revision    : 1.0 - initial release
// ============================================================================
module io_access_decoder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int BASE_ADDR  = 0
) (
    input  wire logic            Clock,
    input  wire logic            Reset,
    io_access_decoder_if.slave   bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_BASE = ADDR_WIDTH'(BASE_ADDR);
    // Wide enough to compare a wrapped offset against NUM_REGS without truncation.
    localparam int c_CW = ADDR_WIDTH + 8;

    logic [1:0]            r_state;
    logic [1:0]            w_nextState;

    logic                  r_wrEn;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wrData;
    logic [DATA_WIDTH-1:0] r_wrDataHold;
    logic [DATA_WIDTH-1:0] r_rdCapture;
    logic                  r_unmapped;

    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_inRange;
    logic [NUM_REGS-1:0]   w_decSel;
    logic [DATA_WIDTH-1:0] w_sliceData;
    logic                  w_isStatus;
    logic [DATA_WIDTH-1:0] w_statusData;
    logic                  w_unmapped;
    logic [DATA_WIDTH-1:0] w_captureData;

    // Address decode from the latched request.
    always_comb begin
        w_offset  = r_addr - c_BASE;
        w_inRange = (r_addr >= c_BASE) && (c_CW'(w_offset) < c_CW'(NUM_REGS));
        w_decSel  = w_inRange ? (NUM_REGS'(1) << w_offset) : '0;
        w_sliceData = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_decSel[i]) begin
                w_sliceData = w_sliceData | bus.Reg_RdData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef IO_ERR_STATUS_EN
    logic [7:0] r_errCount;

    always_comb begin
        w_isStatus   = (r_addr >= c_BASE) && (c_CW'(w_offset) == c_CW'(NUM_REGS));
        w_statusData = DATA_WIDTH'(r_errCount);
    end

    // Own-address accesses are never unmapped, so they cannot bump the count.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_errCount <= 8'd0;
        end else if (r_state == c_ACCESS && w_isStatus && r_wrEn) begin
            r_errCount <= 8'd0;
        end else if (r_state == c_RESP && r_unmapped && r_errCount != 8'hFF) begin
            r_errCount <= r_errCount + 8'd1;
        end
    end
`else
    always_comb begin
        w_isStatus   = 1'b0;
        w_statusData = '0;
    end
`endif

    always_comb begin
        w_unmapped = !w_inRange && !w_isStatus;
        if (r_wrEn) begin
            w_captureData = '0;
        end else if (w_inRange) begin
            w_captureData = w_sliceData;
        end else if (w_isStatus) begin
            w_captureData = w_statusData;
        end else begin
            w_captureData = '0;
        end
    end

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:   if (bus.Cpu_Req) w_nextState = c_ACCESS;
            c_ACCESS: w_nextState = c_RESP;
            c_RESP:   w_nextState = c_IDLE;
            default:  w_nextState = c_IDLE;
        endcase
    end

    // Request latch and response capture
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_wrEn       <= 1'b0;
            r_addr       <= '0;
            r_wrData     <= '0;
            r_wrDataHold <= '0;
            r_rdCapture  <= '0;
            r_unmapped   <= 1'b0;
        end else begin
            if (r_state == c_IDLE && bus.Cpu_Req) begin
                r_wrEn   <= bus.Cpu_WrEn;
                r_addr   <= bus.Cpu_Addr;
                r_wrData <= bus.Cpu_WrData;
            end
            if (r_state == c_ACCESS) begin
                r_rdCapture <= w_captureData;
                r_unmapped  <= w_unmapped;
                if (w_inRange) begin
                    r_wrDataHold <= r_wrData;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        bus.Reg_Select = '0;
        bus.Reg_WrEn   = 1'b0;
        bus.Reg_WrData = r_wrDataHold;
        bus.Cpu_Ready  = 1'b0;
        bus.Cpu_Error  = 1'b0;
        bus.Cpu_RdData = '0;
        case (r_state)
            c_ACCESS: begin
                bus.Reg_Select = w_decSel;
                bus.Reg_WrEn   = r_wrEn && w_inRange;
                if (w_inRange) bus.Reg_WrData = r_wrData;
            end
            c_RESP: begin
                bus.Cpu_Ready  = 1'b1;
                bus.Cpu_Error  = r_unmapped;
                bus.Cpu_RdData = r_rdCapture;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_io_access_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_access_decoder
// Description : Directed self-checking bench for io_access_decoder with a
//               simple register-slice model behind the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_access_decoder;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 8;
    localparam int BA = 16;

    logic Clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] sliceMem [NR];

    io_access_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) bus ();

    io_access_decoder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR),
        .BASE_ADDR  (BA)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Register slices: preset on reset, written on strobe AND select.
    always @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < NR; i++) sliceMem[i] <= 32'h1000_0000 + 32'(i);
            sliceMem[0] <= 32'hCAFE_0000;
            sliceMem[5] <= 32'h1234_5678;
        end else if (bus.Reg_WrEn) begin
            for (int i = 0; i < NR; i++)
                if (bus.Reg_Select[i]) sliceMem[i] <= bus.Reg_WrData;
        end
    end

    always_comb begin
        for (int i = 0; i < NR; i++) bus.Reg_RdData[i*DW +: DW] = sliceMem[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One full access; entered and left at #1 after an edge with the DUT in IDLE.
    task automatic access(input string tag, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [NR-1:0] expSel,
                          input logic expErr, input logic [DW-1:0] expRd);
        bus.Cpu_Req    = 1'b1;
        bus.Cpu_WrEn   = wr;
        bus.Cpu_Addr   = addr;
        bus.Cpu_WrData = data;
        @(posedge Clock); #1;
        bus.Cpu_Req = 1'b0;
        chk({tag, ".acc.sel"},   32'(bus.Reg_Select), 32'(expSel));
        chk({tag, ".acc.wren"},  32'(bus.Reg_WrEn),   32'(wr && (expSel != '0)));
        chk({tag, ".acc.ready"}, 32'(bus.Cpu_Ready),  32'd0);
        if (expSel != '0) chk({tag, ".acc.wdata"}, bus.Reg_WrData, data);
        @(posedge Clock); #1;
        chk({tag, ".rsp.ready"}, 32'(bus.Cpu_Ready),  32'd1);
        chk({tag, ".rsp.error"}, 32'(bus.Cpu_Error),  32'(expErr));
        chk({tag, ".rsp.rdata"}, bus.Cpu_RdData,      expRd);
        chk({tag, ".rsp.sel"},   32'(bus.Reg_Select), 32'd0);
        chk({tag, ".rsp.wren"},  32'(bus.Reg_WrEn),   32'd0);
        if (expSel != '0) chk({tag, ".rsp.wdata"}, bus.Reg_WrData, data);
        @(posedge Clock); #1;
        chk({tag, ".idle.ready"}, 32'(bus.Cpu_Ready), 32'd0);
        chk({tag, ".idle.rdata"}, bus.Cpu_RdData,     32'd0);
    endtask

    task automatic quickUnmapped();
        bus.Cpu_Req  = 1'b1;
        bus.Cpu_WrEn = 1'b0;
        bus.Cpu_Addr = 8'h00;
        @(posedge Clock); #1;
        bus.Cpu_Req = 1'b0;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, ".ready"}, 32'(bus.Cpu_Ready),  32'd0);
        chk({tag, ".error"}, 32'(bus.Cpu_Error),  32'd0);
        chk({tag, ".rdata"}, bus.Cpu_RdData,      32'd0);
        chk({tag, ".sel"},   32'(bus.Reg_Select), 32'd0);
        chk({tag, ".wren"},  32'(bus.Reg_WrEn),   32'd0);
        chk({tag, ".wdata"}, bus.Reg_WrData,      32'd0);
    endtask

    initial begin
        int pulses;
        logic [AW-1:0] hiUnmapped;
`ifdef IO_ERR_STATUS_EN
        hiUnmapped = 8'h19;
`else
        hiUnmapped = 8'h18;
`endif
        Reset = 1'b0;
        bus.Cpu_Req = 1'b0;
        bus.Cpu_WrEn = 1'b0;
        bus.Cpu_Addr = '0;
        bus.Cpu_WrData = '0;
        @(posedge Clock); @(posedge Clock); #1;
        chkAllZero("reset");
        Reset = 1'b1;
        @(posedge Clock); #1;

        access("wr13", 1'b1, 8'h13, 32'hDEAD_BEEF, 8'h08, 1'b0, 32'd0);
        chk("slice3", sliceMem[3], 32'hDEAD_BEEF);
        access("rd15", 1'b0, 8'h15, 32'h0, 8'h20, 1'b0, 32'h1234_5678);
        access("rd13", 1'b0, 8'h13, 32'h0, 8'h08, 1'b0, 32'hDEAD_BEEF);
        access("rd17", 1'b0, 8'h17, 32'h0, 8'h80, 1'b0, 32'h1000_0007);
        access("wr0F", 1'b1, 8'h0F, 32'h1111_1111, 8'h00, 1'b1, 32'd0);
        access("wrHi", 1'b1, hiUnmapped, 32'h2222_2222, 8'h00, 1'b1, 32'd0);
        access("rdFF", 1'b0, 8'hFF, 32'h0, 8'h00, 1'b1, 32'd0);
        access("rd00", 1'b0, 8'h00, 32'h0, 8'h00, 1'b1, 32'd0);
        chk("slicesUntouched", sliceMem[7], 32'h1000_0007);

        // Held request: Ready pulses expected in cycles 2, 5 and 8.
        pulses = 0;
        bus.Cpu_Req = 1'b1;
        bus.Cpu_WrEn = 1'b0;
        bus.Cpu_Addr = 8'h10;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("held.ready%0d", k), 32'(bus.Cpu_Ready), 32'((k % 3) == 2));
            if (bus.Cpu_Ready) begin
                pulses++;
                chk($sformatf("held.rdata%0d", k), bus.Cpu_RdData, 32'hCAFE_0000);
            end
            @(posedge Clock); #1;
        end
        bus.Cpu_Req = 1'b0;
        chk("held.pulses", 32'(pulses), 32'd3);
        @(posedge Clock); #1;
        chk("held.noReaccept", 32'(bus.Reg_Select), 32'd0);

        // Reset during ACCESS of a write.
        bus.Cpu_Req = 1'b1;
        bus.Cpu_WrEn = 1'b1;
        bus.Cpu_Addr = 8'h11;
        bus.Cpu_WrData = 32'h55AA_55AA;
        @(posedge Clock); #1;
        bus.Cpu_Req = 1'b0;
        chk("midrst.accWren", 32'(bus.Reg_WrEn), 32'd1);
        Reset = 1'b0;
        @(posedge Clock); #1;
        chkAllZero("midrst");
        Reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock); #1;
            chk($sformatf("midrst.ready%0d", k), 32'(bus.Cpu_Ready), 32'd0);
            chk($sformatf("midrst.wren%0d", k),  32'(bus.Reg_WrEn),  32'd0);
        end

`ifdef IO_ERR_STATUS_EN
        for (int k = 0; k < 3; k++) quickUnmapped();
        access("cnt3", 1'b0, 8'h18, 32'h0, 8'h00, 1'b0, 32'd3);
        access("cntClr", 1'b1, 8'h18, 32'hFFFF_FFFF, 8'h00, 1'b0, 32'd0);
        access("cnt0", 1'b0, 8'h18, 32'h0, 8'h00, 1'b0, 32'd0);
        for (int k = 0; k < 300; k++) quickUnmapped();
        access("cntSat", 1'b0, 8'h18, 32'h0, 8'h00, 1'b0, 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
